neurotransmitter_scheduler: RTL and testbench

- Owns the 10-bit neurotransmitter level vector.
- Once per scheduling slot, a single shared update unit services exactly one channel, in round-robin order: CORT, DOP, GABA, NE, SER.
- The update unit consumes the inc/dec/fast outputs of the five per-transmitter regulators. It integrates them in per-channel pressure counters and moves each 2-bit level one step when that channel's counter crosses a threshold.
- Its level output feeds back into every regulator and into the emotional-state logic.

---
 rtl/neurotransmitter_scheduler.sv | 141 ++++++++++++++
 tb/tb_neurotransmitter_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/neurotransmitter_scheduler.sv
// Neurotransmitter level scheduler.
// Holds five 2-bit transmitter levels and services one channel per scheduling slot in
// round-robin order (CORT, DOP, GABA, NE, SER). A serviced channel integrates its
// regulator requests in a pressure counter and moves its level one step when the counter
// reaches THRESH.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   run; low freezes divider, pointer, counters and levels
//   inc, dec, fast [4:0]     per-channel regulator requests (bit0 CORT .. bit4 SER)
//   load, load_value [9:0]   synchronous reload of all levels (wins over service)
//   neurotransmitter_level   packed levels, channel c at [2c+1:2c]
//   update_strobe            one-cycle pulse, a level changed on the previous edge
//   update_ch [2:0]          channel of the last level change (held between strobes)
//   round_done               one-cycle pulse after channel 4 has been serviced
module neurotransmitter_scheduler #(
  parameter int unsigned TICK_DIV    = 16,
  parameter int unsigned THRESH      = 4,
  parameter logic [9:0]  RESET_LEVEL = 10'h155
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] inc,
  input  logic [4:0] dec,
  input  logic [4:0] fast,
  input  logic       load,
  input  logic [9:0] load_value,
  output logic [9:0] neurotransmitter_level,
  output logic       update_strobe,
  output logic [2:0] update_ch,
  output logic       round_done
);

  localparam int unsigned DivW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);
  localparam logic [CntW:0]   Thresh = (CntW + 1)'(THRESH);
  localparam logic [2:0]      LastCh = 3'd4;

  logic [DivW-1:0]           div_q, div_d;
  logic [2:0]                ptr_q, ptr_d;
  logic [4:0][CntW-1:0]      cnt_q, cnt_d;
  logic [4:0]                up_q, up_d;
  logic [9:0]                level_q, level_d;
  logic                      strobe_q, strobe_d;
  logic [2:0]                ch_q, ch_d;
  logic                      round_q, round_d;

  logic                      service;
  logic                      req_up, req_dn;
  logic [3:0]                lvl_idx;
  logic [1:0]                cur_lvl;
  logic [CntW:0]             step, sum;

  assign service = enable && (div_q == DivMax);
  assign req_up  = inc[ptr_q] & ~dec[ptr_q];
  assign req_dn  = dec[ptr_q] & ~inc[ptr_q];
  assign lvl_idx = {ptr_q, 1'b0};
  assign cur_lvl = level_q[lvl_idx +: 2];
  assign step    = fast[ptr_q] ? (CntW + 1)'(2) : (CntW + 1)'(1);
  // One bit wider than the counter so the threshold compare never sees a wrapped sum.
  assign sum     = {1'b0, cnt_q[ptr_q]} + step;

  always_comb begin
    div_d    = div_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    up_d     = up_q;
    level_d  = level_q;
    strobe_d = 1'b0;
    round_d  = 1'b0;
    ch_d     = ch_q;

    if (load) begin
      level_d = load_value;
      cnt_d   = '0;
      up_d    = '1;
      div_d   = '0;
      ptr_d   = '0;
    end else if (enable) begin
      div_d = service ? '0 : div_q + DivW'(1);
      if (service) begin
        ptr_d   = (ptr_q == LastCh) ? 3'd0 : ptr_q + 3'd1;
        round_d = (ptr_q == LastCh);
        if (req_up ^ req_dn) begin
          if (req_up != up_q[ptr_q]) begin
            // Reversal restarts integration in the new direction.
            up_d[ptr_q]  = req_up;
            cnt_d[ptr_q] = step[CntW-1:0];
          end else if (sum >= Thresh) begin
            cnt_d[ptr_q] = '0;
            // Saturated channels swallow the step without a strobe.
            if (req_up && (cur_lvl != 2'd3)) begin
              level_d[lvl_idx +: 2] = cur_lvl + 2'd1;
              strobe_d              = 1'b1;
              ch_d                  = ptr_q;
            end else if (req_dn && (cur_lvl != 2'd0)) begin
              level_d[lvl_idx +: 2] = cur_lvl - 2'd1;
              strobe_d              = 1'b1;
              ch_d                  = ptr_q;
            end
          end else begin
            cnt_d[ptr_q] = sum[CntW-1:0];
          end
        end else begin
          // Hold or conflicting requests drain the pressure.
          cnt_d[ptr_q] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      up_q     <= '1;
      level_q  <= RESET_LEVEL;
      strobe_q <= 1'b0;
      ch_q     <= '0;
      round_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      level_q  <= level_d;
      strobe_q <= strobe_d;
      ch_q     <= ch_d;
      round_q  <= round_d;
    end
  end

  assign neurotransmitter_level = level_q;
  assign update_strobe          = strobe_q;
  assign update_ch              = ch_q;
  assign round_done             = round_q;

endmodule

// File: tb/tb_neurotransmitter_scheduler.sv
// Scoreboard bench for neurotransmitter_scheduler. The driver applies stimulus at the
// falling edge, advances a behavioural model (enabled-cycle count, per-channel level and
// pressure arrays) and queues the expected state for the following rising edge. A monitor
// checks every cycle against that queue.
module tb_neurotransmitter_scheduler;

  localparam int TICK_DIV = 16;
  localparam int THRESH   = 4;
  localparam logic [9:0] RESET_LEVEL = 10'h155;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] inc = '0, dec = '0, fast = '0;
  logic       load = 1'b0;
  logic [9:0] load_value = '0;
  logic [9:0] neurotransmitter_level;
  logic       update_strobe;
  logic [2:0] update_ch;
  logic       round_done;

  neurotransmitter_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .THRESH     (THRESH),
    .RESET_LEVEL(RESET_LEVEL)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .inc                   (inc),
    .dec                   (dec),
    .fast                  (fast),
    .load                  (load),
    .load_value            (load_value),
    .neurotransmitter_level(neurotransmitter_level),
    .update_strobe         (update_strobe),
    .update_ch             (update_ch),
    .round_done            (round_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned stamp;
    logic [9:0]  lvl;
    logic [2:0]  ch;
  } cyc_rec_t;

  typedef struct {
    int unsigned stamp;
    logic        strobe;
    logic        rnd;
  } evt_rec_t;

  cyc_rec_t lvl_q[$];
  evt_rec_t evt_q[$];

  // Behavioural model state.
  int m_lvl[5];
  int m_cnt[5];
  bit m_up[5];
  int m_en;
  int m_ch;

  function automatic void check(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [9:0] m_vec();
    logic [9:0] v;
    for (int c = 0; c < 5; c++) v[2*c +: 2] = 2'(m_lvl[c]);
    return v;
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < 5; c++) begin
      m_lvl[c] = 1;
      m_cnt[c] = 0;
      m_up[c]  = 1'b1;
    end
    m_en = 0;
    m_ch = 0;
    lvl_q.delete();
    evt_q.delete();
  endfunction

  task automatic step(input logic en, input logic [4:0] i, input logic [4:0] d,
                      input logic [4:0] f, input logic ld, input logic [9:0] lv);
    bit s, r;
    int c, dir, stp, nl;
    @(negedge clk);
    rst = 1'b0;
    enable = en; inc = i; dec = d; fast = f; load = ld; load_value = lv;
    s = 1'b0;
    r = 1'b0;
    if (ld) begin
      for (int k = 0; k < 5; k++) begin
        m_lvl[k] = int'(lv[2*k +: 2]);
        m_cnt[k] = 0;
        m_up[k]  = 1'b1;
      end
      m_en = 0;
    end else if (en) begin
      m_en++;
      if (m_en % TICK_DIV == 0) begin
        c   = (m_en / TICK_DIV - 1) % 5;
        dir = (i[c] && !d[c]) ? 1 : ((d[c] && !i[c]) ? -1 : 0);
        stp = f[c] ? 2 : 1;
        if (dir == 0) begin
          m_cnt[c] = 0;
        end else if ((dir > 0) != m_up[c]) begin
          m_up[c]  = (dir > 0);
          m_cnt[c] = stp;
        end else if (m_cnt[c] + stp >= THRESH) begin
          m_cnt[c] = 0;
          nl = m_lvl[c] + dir;
          if (nl >= 0 && nl <= 3) begin
            m_lvl[c] = nl;
            m_ch     = c;
            s        = 1'b1;
          end
        end else begin
          m_cnt[c] = m_cnt[c] + stp;
        end
        r = (c == 4);
        if (m_en == 5 * TICK_DIV) m_en = 0;
      end
    end
    lvl_q.push_back('{stamp: cyc + 1, lvl: m_vec(), ch: 3'(m_ch)});
    if (s || r) evt_q.push_back('{stamp: cyc + 1, strobe: s, rnd: r});
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("reset_level", neurotransmitter_level, RESET_LEVEL);
    check("reset_strobe", update_strobe, 0);
    check("reset_round", round_done, 0);
    check("reset_ch", update_ch, 0);
    m_reset();
    repeat (2) @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bit has_rec, exp_p, dut_p;
      cyc_rec_t cr;
      evt_rec_t er;
      has_rec = (lvl_q.size() > 0) && (lvl_q[0].stamp == cyc);
      check("cycle_record", has_rec, 1);
      if (has_rec) begin
        cr = lvl_q.pop_front();
        check("level", neurotransmitter_level, cr.lvl);
        check("update_ch", update_ch, cr.ch);
      end
      exp_p = (evt_q.size() > 0) && (evt_q[0].stamp == cyc);
      dut_p = update_strobe || round_done;
      check("pulse_present", dut_p, exp_p);
      if (exp_p) begin
        er = evt_q.pop_front();
        check("update_strobe", update_strobe, er.strobe);
        check("round_done", round_done, er.rnd);
      end
    end
  end

  initial begin
    logic [4:0] ri, rd, rf;
    int len;
    m_reset();
    repeat (2) @(posedge clk);

    // Slow CORT increase: level 01 -> 10 on the fourth CORT service (strobe at cycle 256).
    repeat (270) step(1'b1, 5'b00001, 5'b0, 5'b0, 1'b0, '0);

    // Fast SER decrease: 01 -> 00 after two services, then saturated.
    do_reset();
    repeat (400) step(1'b1, 5'b0, 5'b10000, 5'b10000, 1'b0, '0);

    // NE direction flip: three up services, then one down service.
    do_reset();
    repeat (240) step(1'b1, 5'b01000, 5'b0, 5'b0, 1'b0, '0);
    repeat (80) step(1'b1, 5'b0, 5'b01000, 5'b0, 1'b0, '0);

    // DOP conflicting requests clear the counter.
    repeat (160) step(1'b1, 5'b00010, 5'b00010, 5'b0, 1'b0, '0);

    // Load coinciding with a service cycle.
    while ((m_en % TICK_DIV) != TICK_DIV - 1) step(1'b1, 5'b11111, 5'b0, 5'b0, 1'b0, '0);
    step(1'b1, 5'b11111, 5'b0, 5'b0, 1'b1, 10'h3FF);
    repeat (100) step(1'b1, 5'b11111, 5'b0, 5'b11111, 1'b0, '0);
    repeat (200) step(1'b1, 5'b0, 5'b11111, 5'b01010, 1'b0, '0);

    // Freeze for 37 cycles mid-slot.
    while ((m_en % TICK_DIV) != 7) step(1'b1, 5'b00101, 5'b0, 5'b0, 1'b0, '0);
    repeat (37) step(1'b0, 5'b11111, 5'b0, 5'b11111, 1'b0, '0);
    repeat (200) step(1'b1, 5'b00101, 5'b0, 5'b0, 1'b0, '0);

    // Randomised segments: request masks held long enough to integrate.
    for (int seg = 0; seg < 40; seg++) begin
      if (seg == 20) do_reset();
      ri  = 5'($urandom);
      rd  = 5'($urandom);
      rf  = 5'($urandom);
      len = $urandom_range(50, 200);
      for (int k = 0; k < len; k++) begin
        step($urandom_range(0, 9) != 0, ri, rd, rf, $urandom_range(0, 299) == 0,
             10'($urandom));
      end
    end

    repeat (3) step(1'b0, 5'b0, 5'b0, 5'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    check("evt_drain", evt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
